// File: rtl/coco_spi_cmd_master.sv
// Host-side SPI mode-0 master for the FDC CPLD byte command protocol.
// Serialises one high-level command per handshake into a framed 1..3 byte SPI transfer.
module coco_spi_cmd_master #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned GAP_CYCLES = 16,
   parameter int unsigned SS_SETUP   = 4
) (
   input  logic        clock_50,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [15:0] cmd_addr,
   input  logic [7:0]  cmd_wdata,
   output logic        cmd_done,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        busy,
   output logic        sclk,
   output logic        mosi,
   input  logic        miso,
   output logic        ss
);

   localparam int unsigned BIT_CYCLES = 2 * CLK_DIV;
   localparam int unsigned CNT_MAX_A  = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_MAX    = (CNT_MAX_A > SS_SETUP) ? CNT_MAX_A : SS_SETUP;
   localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] RISE_AT   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] FALL_AT   = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(SS_SETUP - 1);

   localparam logic [2:0] OP_SETADDR = 3'd0;
   localparam logic [2:0] OP_WRITE   = 3'd1;
   localparam logic [2:0] OP_READ    = 3'd2;
   localparam logic [2:0] OP_GRAB    = 3'd3;
   localparam logic [2:0] OP_RELEASE = 3'd4;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_SETUP = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;
   localparam logic [2:0] S_HOLD  = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   logic [2:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       bit_cnt, bit_cnt_nxt;
   logic [1:0]       byte_idx, byte_idx_nxt;
   logic [1:0]       last_idx, last_idx_nxt;
   logic [1:0]       next_idx;
   logic [2:0]       op_q, op_q_nxt;
   logic [7:0]       byte_list [3];
   logic [7:0]       byte_list_nxt [3];
   logic [7:0]       tx_sr, tx_sr_nxt;
   logic [7:0]       rx_sr, rx_sr_nxt;
   logic             cmd_ready_nxt, cmd_done_nxt, rsp_valid_nxt, busy_nxt;
   logic             sclk_nxt, mosi_nxt, ss_nxt;
   logic [7:0]       rsp_data_nxt;

   assign next_idx = byte_idx + 2'd1;

   // State and registered outputs
   always_ff @(posedge clock_50) begin
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         byte_idx  <= '0;
         last_idx  <= '0;
         op_q      <= '0;
         byte_list <= '{default: 8'h00};
         tx_sr     <= '0;
         rx_sr     <= '0;
         cmd_ready <= 1'b1;
         cmd_done  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= 8'h00;
         busy      <= 1'b0;
         sclk      <= 1'b0;
         mosi      <= 1'b0;
         ss        <= 1'b1;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         byte_idx  <= byte_idx_nxt;
         last_idx  <= last_idx_nxt;
         op_q      <= op_q_nxt;
         byte_list <= byte_list_nxt;
         tx_sr     <= tx_sr_nxt;
         rx_sr     <= rx_sr_nxt;
         cmd_ready <= cmd_ready_nxt;
         cmd_done  <= cmd_done_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_data  <= rsp_data_nxt;
         busy      <= busy_nxt;
         sclk      <= sclk_nxt;
         mosi      <= mosi_nxt;
         ss        <= ss_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt + CNT_W'(1);
      bit_cnt_nxt   = bit_cnt;
      byte_idx_nxt  = byte_idx;
      last_idx_nxt  = last_idx;
      op_q_nxt      = op_q;
      byte_list_nxt = byte_list;
      tx_sr_nxt     = tx_sr;
      rx_sr_nxt     = rx_sr;
      cmd_ready_nxt = cmd_ready;
      cmd_done_nxt  = 1'b0;
      rsp_valid_nxt = 1'b0;
      rsp_data_nxt  = rsp_data;
      busy_nxt      = busy;
      sclk_nxt      = sclk;
      mosi_nxt      = mosi;
      ss_nxt        = ss;

      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (cmd_valid && cmd_ready) begin
               op_q_nxt      = cmd_op;
               cmd_ready_nxt = 1'b0;
               busy_nxt      = 1'b1;
               state_nxt     = S_LOAD;
               case (cmd_op)
                  OP_SETADDR: begin
                     byte_list_nxt[0] = 8'h01;
                     byte_list_nxt[1] = cmd_addr[15:8];
                     byte_list_nxt[2] = cmd_addr[7:0];
                     last_idx_nxt     = 2'd2;
                  end
                  OP_WRITE: begin
                     byte_list_nxt[0] = 8'h02;
                     byte_list_nxt[1] = cmd_wdata;
                     last_idx_nxt     = 2'd1;
                  end
                  OP_READ: begin
                     byte_list_nxt[0] = 8'h03;
                     byte_list_nxt[1] = 8'h00;
                     last_idx_nxt     = 2'd1;
                  end
                  OP_GRAB: begin
                     byte_list_nxt[0] = 8'h04;
                     last_idx_nxt     = 2'd0;
                  end
                  OP_RELEASE: begin
                     byte_list_nxt[0] = 8'h05;
                     last_idx_nxt     = 2'd0;
                  end
                  default: begin
                     // Reserved ops complete immediately without touching the bus
                     state_nxt    = S_DONE;
                     cmd_done_nxt = 1'b1;
                  end
               endcase
            end
         end

         S_LOAD: begin
            state_nxt    = S_SETUP;
            cnt_nxt      = '0;
            byte_idx_nxt = 2'd0;
            tx_sr_nxt    = byte_list[0];
            mosi_nxt     = byte_list[0][7];
            ss_nxt       = 1'b0;
         end

         S_SETUP: begin
            if (cnt == SETUP_END) begin
               state_nxt   = S_SHIFT;
               cnt_nxt     = '0;
               bit_cnt_nxt = 3'd0;
            end
         end

         S_SHIFT: begin
            if (cnt == RISE_AT) begin
               sclk_nxt  = 1'b1;
               rx_sr_nxt = {rx_sr[6:0], miso};
            end
            if (cnt == FALL_AT) begin
               sclk_nxt    = 1'b0;
               cnt_nxt     = '0;
               bit_cnt_nxt = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  if (byte_idx == last_idx) begin
                     state_nxt = S_HOLD;
                     mosi_nxt  = 1'b0;
                  end else begin
                     state_nxt    = S_GAP;
                     byte_idx_nxt = next_idx;
                     tx_sr_nxt    = byte_list[next_idx];
                     mosi_nxt     = byte_list[next_idx][7];
                  end
               end else begin
                  tx_sr_nxt = {tx_sr[6:0], 1'b0};
                  mosi_nxt  = tx_sr[6];
               end
            end
         end

         S_GAP: begin
            if (cnt == GAP_END) begin
               state_nxt = S_SHIFT;
               cnt_nxt   = '0;
            end
         end

         S_HOLD: begin
            if (cnt == SETUP_END) begin
               state_nxt    = S_DONE;
               cnt_nxt      = '0;
               ss_nxt       = 1'b1;
               cmd_done_nxt = 1'b1;
               // The last byte shifted in is the reply to the dummy byte
               if (op_q == OP_READ) begin
                  rsp_valid_nxt = 1'b1;
                  rsp_data_nxt  = rx_sr;
               end
            end
         end

         S_DONE: begin
            state_nxt     = S_IDLE;
            cnt_nxt       = '0;
            busy_nxt      = 1'b0;
            cmd_ready_nxt = 1'b1;
         end

         default: begin
            state_nxt     = S_IDLE;
            cnt_nxt       = '0;
            busy_nxt      = 1'b0;
            cmd_ready_nxt = 1'b1;
            ss_nxt        = 1'b1;
            sclk_nxt      = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/coco_spi_cmd_master.md
Name: coco_spi_cmd_master

Overview:
- Host-side SPI master that drives the FDC CPLD's byte-oriented SPI command protocol from the controlling processor/FPGA.
- Accepts one high-level command per handshake and serialises it into the protocol's command and operand bytes:
  - set address: 0x01 hh ll
  - write byte: 0x02 dd
  - read byte: 0x03 then a dummy byte
  - grab bus: 0x04
  - release bus: 0x05
- Generates SCK, SS and MOSI, samples MISO, and returns read data to the requester.

Parameters:
- CLK_DIV, 4, clock_50 cycles per SCK half-period (≥2).
- GAP_CYCLES, 16, idle clock_50 cycles with SCK low between bytes of one command. This gives the slave time to decode and to finish its SRAM write strobe (≥8).
- SS_SETUP, 4, clock_50 cycles from SS falling to the first SCK rising edge, and from the last SCK falling edge to SS rising.

Ports:
- clock_50  input  1  system clock
- reset  input  1  synchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  block can accept a command
- cmd_op  input  3  0=SETADDR, 1=WRITE, 2=READ, 3=GRAB, 4=RELEASE, 5-7 reserved
- cmd_addr  input  16  address operand for SETADDR
- cmd_wdata  input  8  data operand for WRITE
- cmd_done  output  1  one-cycle pulse when a command has completed
- rsp_valid  output  1  one-cycle pulse when rsp_data is valid (READ only)
- rsp_data  output  8  byte read from the slave
- busy  output  1  a command is in progress
- sclk  output  1  SPI clock, idles low
- mosi  output  1  SPI data out, MSB first
- miso  input  1  SPI data in
- ss  output  1  slave select, active-low

Behaviour:
- Reset (clock_50 edge with reset=0), applied even mid-transfer:
  - Outputs: ss=1, sclk=0, mosi=0, cmd_ready=1, busy=0, cmd_done=0, rsp_valid=0, rsp_data=0x00.
  - All counters clear; the FSM returns to IDLE.
  - A truncated frame is abandoned; the slave resynchronises on SS.
- Handshake:
  - A command is accepted on a cycle with cmd_valid & cmd_ready.
  - cmd_op, cmd_addr and cmd_wdata are captured on that edge.
  - cmd_ready drops the next cycle and stays low until the cycle after cmd_done.
- Frame byte sequences; bytes are loaded into a 3-entry byte list with a 2-bit byte counter:
  - SETADDR: 0x01, addr[15:8], addr[7:0].
  - WRITE: 0x02, wdata.
  - READ: 0x03, 0x00.
  - GRAB: 0x04.
  - RELEASE: 0x05.
- Reserved ops (5-7): accepted, no SPI activity (ss stays 1), cmd_done pulses 1 cycle after accept.
- FSM states: IDLE -> SETUP -> SHIFT -> (GAP -> SHIFT)* -> HOLD -> DONE -> IDLE.
  - SETUP: ss=0, mosi=bit7 of byte 0, waits SS_SETUP cycles.
  - SHIFT: 8 bits, mode 0:
    - sclk rises after CLK_DIV cycles; miso is sampled into the shift register on that same edge.
    - sclk falls CLK_DIV cycles later; mosi advances to the next bit on the falling edge.
    - 3-bit bit counter; byte time = 16*CLK_DIV cycles.
  - GAP: entered after the last bit of a byte if more bytes remain; sclk=0, ss stays 0, lasts GAP_CYCLES; mosi presents bit7 of the next byte.
  - HOLD: after the final byte, SS_SETUP cycles with ss=0, then ss=1.
  - DONE: one cycle; cmd_done=1; for READ also rsp_valid=1 and rsp_data = byte captured during the second (dummy) byte.
  - The MISO byte captured during 0x03 is discarded.
- rsp_data holds its value until the next completed READ.
- busy=1 from the cycle after accept through the DONE cycle.
- cmd_valid during busy is ignored (not queued).
- Command-to-done latency in cycles, for a command of n bytes: 1 + SS_SETUP + n*16*CLK_DIV + (n-1)*GAP_CYCLES + SS_SETUP + 1.
- Address auto-increment after READ/WRITE is a slave property; this block does not track or model the address.

Test Plan:
- Reset, then GRAB with CLK_DIV=4 -> ss low for exactly one byte, MOSI 0x04 sampled on 8 rising sclk edges, cmd_done 1 + 4 + 64 + 4 + 1 = 74 cycles after accept, ss returns 1.
- SETADDR addr=0x8123 -> slave model receives 0x01, 0x81, 0x23 in one ss-low frame, with ≥16 low-sclk cycles between bytes; cmd_ready low throughout.
- WRITE 0xA5, then READ with the slave model returning 0x3C on the dummy byte -> MOSI bytes 0x02,0xA5 then 0x03,0x00; rsp_valid one pulse with rsp_data=0x3C.
- READ with MISO=0xFF during byte 0x03 and 0x5A during the dummy byte -> rsp_data=0x5A (first byte discarded).
- Reset asserted mid-SETADDR (during the second byte) -> next edge ss=1, sclk=0, cmd_ready=1, no cmd_done or rsp_valid; a subsequent RELEASE completes normally with byte 0x05.
- cmd_op=6, and cmd_valid held high during a busy WRITE -> reserved op gives cmd_done with no ss activity; the held request is accepted only after the WRITE's cmd_done, exactly once per cmd_ready cycle.
